// File: rtl/dcache_tbus_arb_pkg.sv
// Shared widths, tbus op-type codes and the enums used by the dcache tbus arbiter.
package dcache_tbus_arb_pkg;

  localparam int unsigned RESULT_W = 64;
  localparam int unsigned SRC_W    = 64;
  localparam int unsigned MASK_W   = 64;
  localparam int unsigned OPTYPE_W = 2;

  // Zero is deliberately not a legal op code, so a cleared payload register
  // never looks like a real request.
  localparam logic [OPTYPE_W-1:0] TBUS_READ  = 2'b01;
  localparam logic [OPTYPE_W-1:0] TBUS_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_LD = 1'b0,
    OWN_SQ = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/dcache_tbus_arb.sv
// Single-owner arbiter/sequencer for the dcache tbus, shared by the load pipe
// and the store queue. Load has priority; a saturating starvation counter forces
// a waiting store through after STARVE_LIMIT load grants. A redirect flush
// kills an in-flight load's completion but never breaks the bus handshake.
// CNT_W must be wide enough that 2**CNT_W > STARVE_LIMIT.
module dcache_tbus_arb
  import dcache_tbus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_valid,
  // load requester
  input  logic                ld2arb_tbus_index_valid,
  output logic                ld2arb_tbus_index_ready,
  input  logic [RESULT_W-1:0] ld2arb_tbus_index,
  input  logic [OPTYPE_W-1:0] ld2arb_tbus_operation_type,
  output logic [RESULT_W-1:0] ld2arb_tbus_read_data,
  output logic                ld2arb_tbus_operation_done,
  // store-queue requester
  input  logic                sq2arb_tbus_index_valid,
  output logic                sq2arb_tbus_index_ready,
  input  logic [RESULT_W-1:0] sq2arb_tbus_index,
  input  logic [SRC_W-1:0]    sq2arb_tbus_write_data,
  input  logic [MASK_W-1:0]   sq2arb_tbus_write_mask,
  input  logic [OPTYPE_W-1:0] sq2arb_tbus_operation_type,
  output logic [RESULT_W-1:0] sq2arb_tbus_read_data,
  output logic                sq2arb_tbus_operation_done,
  // dcache side
  output logic                arb2dc_tbus_index_valid,
  input  logic                arb2dc_tbus_index_ready,
  output logic [RESULT_W-1:0] arb2dc_tbus_index,
  output logic [SRC_W-1:0]    arb2dc_tbus_write_data,
  output logic [MASK_W-1:0]   arb2dc_tbus_write_mask,
  output logic [OPTYPE_W-1:0] arb2dc_tbus_operation_type,
  input  logic [RESULT_W-1:0] arb2dc_tbus_read_data,
  input  logic                arb2dc_tbus_operation_done
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic                kill_q;
  logic [CNT_W-1:0]    starve_cnt_q;
  logic [RESULT_W-1:0] addr_q;
  logic [SRC_W-1:0]    wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [OPTYPE_W-1:0] optype_q;

  logic ld_req;
  logic sq_win;
  logic ld_win;
  logic in_idle;
  logic complete;

  // Arbitration decision and completion detect for the current cycle.
  always_comb begin
    ld_req   = ld2arb_tbus_index_valid & ~flush_valid;
    sq_win   = sq2arb_tbus_index_valid & (~ld_req | (starve_cnt_q >= LIMIT_C));
    ld_win   = ld_req & ~sq_win;
    in_idle  = (state_q == ST_IDLE);
    complete = ((state_q == ST_REQ) & arb2dc_tbus_index_ready & arb2dc_tbus_operation_done) |
               ((state_q == ST_WAIT) & arb2dc_tbus_operation_done);
  end

  // Grant pulses are combinational so the winner sees acceptance in the same
  // cycle; everything is held at zero while reset is asserted.
  assign ld2arb_tbus_index_ready = reset_n & in_idle & ld_win;
  assign sq2arb_tbus_index_ready = reset_n & in_idle & sq_win;

  // Completion goes only to the owner; a killed load swallows its done.
  assign ld2arb_tbus_operation_done = complete & (owner_q == OWN_LD) & ~kill_q;
  assign sq2arb_tbus_operation_done = complete & (owner_q == OWN_SQ);

  // Read data is broadcast; each requester qualifies it with its own done.
  assign ld2arb_tbus_read_data = reset_n ? arb2dc_tbus_read_data : '0;
  assign sq2arb_tbus_read_data = reset_n ? arb2dc_tbus_read_data : '0;

  assign arb2dc_tbus_index_valid    = (state_q == ST_REQ);
  assign arb2dc_tbus_index          = addr_q;
  assign arb2dc_tbus_write_data     = wdata_q;
  assign arb2dc_tbus_write_mask     = wmask_q;
  assign arb2dc_tbus_operation_type = optype_q;

  // Bus FSM: latch the winner in IDLE, present it in REQ, hold through WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_LD;
      kill_q       <= 1'b0;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      optype_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sq_win) begin
            state_q      <= ST_REQ;
            owner_q      <= OWN_SQ;
            starve_cnt_q <= '0;
            addr_q       <= sq2arb_tbus_index;
            wdata_q      <= sq2arb_tbus_write_data;
            wmask_q      <= sq2arb_tbus_write_mask;
            optype_q     <= sq2arb_tbus_operation_type;
          end else if (ld_win) begin
            state_q  <= ST_REQ;
            owner_q  <= OWN_LD;
            addr_q   <= ld2arb_tbus_index;
            wdata_q  <= '0;
            wmask_q  <= '0;
            optype_q <= ld2arb_tbus_operation_type;
            if (sq2arb_tbus_index_valid && (starve_cnt_q < LIMIT_C)) begin
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_REQ: begin
          if (flush_valid && (owner_q == OWN_LD)) begin
            kill_q <= 1'b1;
          end
          if (arb2dc_tbus_index_ready) begin
            if (arb2dc_tbus_operation_done) begin
              state_q <= ST_IDLE;
              kill_q  <= 1'b0;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush_valid && (owner_q == OWN_LD)) begin
            kill_q <= 1'b1;
          end
          if (arb2dc_tbus_operation_done) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          kill_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_tbus_arb.md
Name: dcache_tbus_arb

Overview:
Single-owner arbiter and sequencer for the dcache tbus, shared by two requesters: the load pipeline (load unit) and the store queue (sq).
- Arbitrates in IDLE, latches the winner's request and presents it to the dcache.
- Holds the bus until the dcache operation completes, then routes completion back to the owner.
- Load has priority; a starvation counter guarantees store drain.
- Redirect flush kills in-flight loads without corrupting the bus protocol.

Parameters:
STARVE_LIMIT, 4, consecutive load grants allowed while a store is waiting before the store is forced to win.
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
flush_valid  in  1  redirect flush; kills the load requester only
ld2arb_tbus_index_valid  in  1  load request valid
ld2arb_tbus_index_ready  out  1  one-cycle grant/accept pulse to load
ld2arb_tbus_index  in  `RESULT_RANGE  load address
ld2arb_tbus_operation_type  in  `TBUS_OPTYPE_RANGE  load op type
ld2arb_tbus_read_data  out  `RESULT_RANGE  read data to load
ld2arb_tbus_operation_done  out  1  load completion
sq2arb_tbus_index_valid  in  1  store request valid (held until done)
sq2arb_tbus_index_ready  out  1  one-cycle grant pulse to sq
sq2arb_tbus_index  in  `RESULT_RANGE  store address
sq2arb_tbus_write_data  in  `SRC_RANGE  store data
sq2arb_tbus_write_mask  in  64  store byte/bit mask
sq2arb_tbus_operation_type  in  `TBUS_OPTYPE_RANGE  store op type (TBUS_WRITE)
sq2arb_tbus_read_data  out  `RESULT_RANGE  read data to sq
sq2arb_tbus_operation_done  out  1  store completion
arb2dc_tbus_index_valid  out  1  request to dcache
arb2dc_tbus_index_ready  in  1  dcache accepts request
arb2dc_tbus_index  out  `RESULT_RANGE  latched address
arb2dc_tbus_write_data  out  `SRC_RANGE  latched data
arb2dc_tbus_write_mask  out  64  latched mask
arb2dc_tbus_operation_type  out  `TBUS_OPTYPE_RANGE  latched op type
arb2dc_tbus_read_data  in  `RESULT_RANGE  dcache read data
arb2dc_tbus_operation_done  in  1  dcache completion

Behaviour:
Reset (asynchronous): state=IDLE, owner=LD, kill=0, starve_cnt=0, payload regs=0. All outputs are 0.

FSM states: IDLE, REQ, WAIT. Owner register: LD or SQ.

IDLE:
- ld_req = ld valid & ~flush_valid.
- sq_win = sq valid & (~ld_req | starve_cnt >= STARVE_LIMIT). Otherwise ld_req wins.
- Winner's index_ready pulses this cycle (combinational). Payload and owner latch; next state REQ.
- Loser's valid is ignored; it must hold.
- For a load winner, write_data and write_mask latch as 0.

REQ:
- arb2dc index_valid=1, payload driven from registers.
- ready & ~done -> WAIT.
- ready & done in the same cycle -> completion handling, then IDLE.

WAIT:
- index_valid=0. done -> completion handling, then IDLE.

Completion handling:
- owner's operation_done = arb2dc done & ~(owner==LD & kill).
- read_data is forwarded combinationally to both requesters at all times.

Latency: grant at cycle N, dcache sees valid at N+1. Minimum one IDLE cycle between operations (back-to-back grant N+2 after a same-cycle ready/done).

Flush:
- flush_valid while owner==LD in REQ/WAIT sets kill.
- The bus is still held until dcache done; done to the load is suppressed. kill clears on return to IDLE.
- Store operations are never killed (committed).

Starvation counter:
- Increments, saturating at STARVE_LIMIT, on each load grant while sq valid.
- Clears on every sq grant.

Reset mid-operation: immediate return to IDLE; the in-flight dcache op is abandoned. Dcache is reset by the same reset_n.

Decomposition:
- Owner enum (LD/SQ) and state enum (IDLE/REQ/WAIT) go in the shared defines alongside `TBUS_OPTYPE_RANGE.
- `TBUS_READ and `TBUS_WRITE stay in shared defines.
- No sub-module; a single FSM plus payload registers.

Test Plan:
- SQ only, addr 0x80001000, data 0xDEADBEEF, mask all-ones: sq ready pulses at cycle 0; arb2dc valid with latched values at cycle 1. Dcache ready at 2, done at 5 -> sq done at 5 only; state IDLE at 6.
- LD and SQ valid together, starve_cnt=0: LD granted. SQ waits with no ready pulse. SQ is granted in the first IDLE cycle after LD done.
- LD asserted continuously, SQ valid throughout, STARVE_LIMIT=4: 4 LD grants, then 5th grant goes to SQ; starve_cnt returns to 0.
- LD granted, flush_valid at cycle 2 (WAIT): ld done suppressed when dcache done arrives; bus stays busy until then. Next grant allowed afterward.
- LD valid with flush_valid in IDLE: no grant. SQ valid same cycle -> SQ granted.
- reset_n low during WAIT (owner SQ): all outputs 0 immediately. After release, state is IDLE and a new SQ request is granted normally.
